regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 123 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with busy scoreboard and sequential clear.
// Define RF_WB_BYPASS_EN for same-cycle writeback-to-read bypass.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IDW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  output logic            ready_o,
  input  logic            wrEn_i,
  input  logic [IDW-1:0]  rdId_i,
  input  logic [XLEN-1:0] rdData_i,
  input  logic [IDW-1:0]  rs1Id_i,
  input  logic [IDW-1:0]  rs2Id_i,
  output logic [XLEN-1:0] rs1Data_o,
  output logic [XLEN-1:0] rs2Data_o,
  input  logic            issue_i,
  input  logic [IDW-1:0]  issueRd_i,
  output logic            rs1Busy_o,
  output logic            rs2Busy_o
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [IDW-1:0] LAST = IDW'(NREGS - 1);

  state_t           r_state;
  state_t           w_stateNext;
  logic [IDW-1:0]   r_clrIdx;
  logic [NREGS-1:0] r_busy;
  logic [XLEN-1:0]  r_mem [NREGS];

  logic            w_ready;
  logic            w_clrWr;
  logic            w_runWr;
  logic            w_runIss;
  logic [XLEN-1:0] w_rs1Data;
  logic [XLEN-1:0] w_rs2Data;
  logic            w_rs1Busy;
  logic            w_rs2Busy;

  // x0 and indices beyond the file are never stored, never busy
  function automatic logic f_inRange(input logic [IDW-1:0] idx);
    return (idx != '0) && (32'(idx) < NREGS);
  endfunction

  assign w_ready = (r_state == RUN);

  always_comb begin
    w_stateNext = r_state;
    w_clrWr     = 1'b0;
    w_runWr     = 1'b0;
    w_runIss    = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_clrWr = 1'b1;
        if (r_clrIdx == LAST) w_stateNext = RUN;
      end
      RUN: begin
        w_runWr  = wrEn_i && f_inRange(rdId_i);
        w_runIss = issue_i && f_inRange(issueRd_i);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_state  <= CLEAR;
      r_clrIdx <= IDW'(1);
      r_busy   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_clrWr && r_clrIdx != LAST) r_clrIdx <= r_clrIdx + IDW'(1);
      // issue set lands after the clear: a new producer wins
      if (w_runWr)  r_busy[rdId_i]    <= 1'b0;
      if (w_runIss) r_busy[issueRd_i] <= 1'b1;
    end
  end

  // array has no reset so it can map onto RAM
  always_ff @(posedge clk_i) begin
    if (w_clrWr)      r_mem[r_clrIdx] <= '0;
    else if (w_runWr) r_mem[rdId_i]   <= rdData_i;
  end

  always_comb begin
    w_rs1Data = '0;
    w_rs1Busy = 1'b0;
    if (w_ready && f_inRange(rs1Id_i)) begin
      w_rs1Data = r_mem[rs1Id_i];
      w_rs1Busy = r_busy[rs1Id_i];
`ifdef RF_WB_BYPASS_EN
      if (w_runWr && rs1Id_i == rdId_i) begin
        w_rs1Data = rdData_i;
        if (!(w_runIss && issueRd_i == rs1Id_i)) w_rs1Busy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    w_rs2Data = '0;
    w_rs2Busy = 1'b0;
    if (w_ready && f_inRange(rs2Id_i)) begin
      w_rs2Data = r_mem[rs2Id_i];
      w_rs2Busy = r_busy[rs2Id_i];
`ifdef RF_WB_BYPASS_EN
      if (w_runWr && rs2Id_i == rdId_i) begin
        w_rs2Data = rdData_i;
        if (!(w_runIss && issueRd_i == rs2Id_i)) w_rs2Busy = 1'b0;
      end
`endif
    end
  end

  assign ready_o   = w_ready;
  assign rs1Data_o = w_rs1Data;
  assign rs2Data_o = w_rs2Data;
  assign rs1Busy_o = w_rs1Busy;
  assign rs2Busy_o = w_rs2Busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors and reset/clear sequences for regfile_scoreboard.
// Second instance (NREGS=24) covers out-of-range indices and a shorter clear.
module tb_regfile_scoreboard;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        ready;
  logic        wrEn;
  logic [4:0]  rdId;
  logic [31:0] rdData;
  logic [4:0]  rs1Id, rs2Id;
  logic [31:0] rs1Data, rs2Data;
  logic        issue;
  logic [4:0]  issueRd;
  logic        rs1Busy, rs2Busy;

  logic        s_ready;
  logic        s_wrEn;
  logic [4:0]  s_rdId;
  logic [31:0] s_rdData;
  logic [4:0]  s_rs1Id, s_rs2Id;
  logic [31:0] s_rs1Data, s_rs2Data;
  logic        s_issue;
  logic [4:0]  s_issueRd;
  logic        s_rs1Busy, s_rs2Busy;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREGS(32)) dut (
    .clk_i(clk), .resetn_i(resetn), .ready_o(ready),
    .wrEn_i(wrEn), .rdId_i(rdId), .rdData_i(rdData),
    .rs1Id_i(rs1Id), .rs2Id_i(rs2Id),
    .rs1Data_o(rs1Data), .rs2Data_o(rs2Data),
    .issue_i(issue), .issueRd_i(issueRd),
    .rs1Busy_o(rs1Busy), .rs2Busy_o(rs2Busy)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(24)) dut_s (
    .clk_i(clk), .resetn_i(resetn), .ready_o(s_ready),
    .wrEn_i(s_wrEn), .rdId_i(s_rdId), .rdData_i(s_rdData),
    .rs1Id_i(s_rs1Id), .rs2Id_i(s_rs2Id),
    .rs1Data_o(s_rs1Data), .rs2Data_o(s_rs2Data),
    .issue_i(s_issue), .issueRd_i(s_issueRd),
    .rs1Busy_o(s_rs1Busy), .rs2Busy_o(s_rs2Busy)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        iss;
    logic [4:0]  ir;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
  } vec_t;

  vec_t tv [16];

  function automatic vec_t mk(
    input logic wr, input logic [4:0] rd, input logic [31:0] wd,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic iss, input logic [4:0] ir,
    input logic [31:0] e1, input logic [31:0] e2,
    input logic b1, input logic b2);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wd = wd; v.r1 = r1; v.r2 = r2;
    v.iss = iss; v.ir = ir; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    else
      npass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrEn = 1'b0; rdId = 5'd0; rdData = 32'd0;
    issue = 1'b0; issueRd = 5'd0;
    s_wrEn = 1'b0; s_rdId = 5'd0; s_rdData = 32'd0;
    s_issue = 1'b0; s_issueRd = 5'd0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n1;
    int n2;
    resetn = 1'b0;
    idle();
    rs1Id = 5'd5; rs2Id = 5'd0;
    s_rs1Id = 5'd0; s_rs2Id = 5'd0;

    tv[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0,
                BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 1'b0);
    tv[1]  = mk(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0,
                32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    tv[2]  = mk(1'b1, 5'd0, 32'h1234, 5'd0, 5'd5, 1'b0, 5'd0,
                32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    tv[3]  = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0,
                32'h0, 32'h0, 1'b0, 1'b0);
    tv[4]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7,
                32'h0, 32'h0, 1'b0, 1'b0);
    tv[5]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0,
                32'h0, 32'h0, 1'b1, 1'b0);
    tv[6]  = tv[5];
    tv[7]  = tv[5];
    tv[8]  = mk(1'b1, 5'd7, 32'h77, 5'd7, 5'd0, 1'b0, 5'd0,
                BYP ? 32'h77 : 32'h0, 32'h0, !BYP, 1'b0);
    tv[9]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0,
                32'h77, 32'h0, 1'b0, 1'b0);
    tv[10] = mk(1'b1, 5'd7, 32'h88, 5'd7, 5'd7, 1'b1, 5'd7,
                BYP ? 32'h88 : 32'h77, BYP ? 32'h88 : 32'h77, 1'b0, 1'b0);
    tv[11] = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0,
                32'h88, 32'h0, 1'b1, 1'b0);
    tv[12] = mk(1'b1, 5'd9, 32'hA5A5A5A5, 5'd7, 5'd9, 1'b0, 5'd0,
                32'h88, BYP ? 32'hA5A5A5A5 : 32'h0, 1'b1, 1'b0);
    tv[13] = mk(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0,
                32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0);
    tv[14] = mk(1'b1, 5'd7, 32'h99, 5'd7, 5'd3, 1'b1, 5'd3,
                BYP ? 32'h99 : 32'h88, 32'h0, !BYP, 1'b0);
    tv[15] = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 1'b0, 5'd0,
                32'h99, 32'h0, 1'b0, 1'b1);

    // reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_rs1data", rs1Data, 32'd0);
      chk("rst_rs1busy", {31'd0, rs1Busy}, 32'd0);
    end
    resetn = 1'b1;
    n1 = 0;
    n2 = 0;
    for (int c = 1; c <= 60 && (n1 == 0 || n2 == 0); c++) begin
      tick();
      if (ready && n1 == 0) n1 = c;
      if (s_ready && n2 == 0) n2 = c;
    end
    chk("clear_cycles_32", n1, 32'd31);
    chk("clear_cycles_24", n2, 32'd23);
    for (int i = 0; i < 32; i++) begin
      rs1Id = 5'(i);
      rs2Id = 5'(31 - i);
      #1;
      chk($sformatf("init_rd_x%0d", i), rs1Data, 32'd0);
      chk($sformatf("init_busy_x%0d", i), {31'd0, rs2Busy}, 32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      wrEn = tv[i].wr; rdId = tv[i].rd; rdData = tv[i].wd;
      rs1Id = tv[i].r1; rs2Id = tv[i].r2;
      issue = tv[i].iss; issueRd = tv[i].ir;
      @(negedge clk);
      chk($sformatf("v%0d_rs1data", i), rs1Data, tv[i].e1);
      chk($sformatf("v%0d_rs2data", i), rs2Data, tv[i].e2);
      chk($sformatf("v%0d_rs1busy", i), {31'd0, rs1Busy}, {31'd0, tv[i].b1});
      chk($sformatf("v%0d_rs2busy", i), {31'd0, rs2Busy}, {31'd0, tv[i].b2});
      tick();
    end
    idle();

    // small file: out-of-range index 28 is inert, last index 23 works
    s_wrEn = 1'b1; s_rdId = 5'd28; s_rdData = 32'h55;
    s_issue = 1'b1; s_issueRd = 5'd28;
    tick();
    s_wrEn = 1'b1; s_rdId = 5'd23; s_rdData = 32'h12345678;
    s_issue = 1'b1; s_issueRd = 5'd22;
    tick();
    idle();
    s_rs1Id = 5'd28; s_rs2Id = 5'd23;
    #1;
    chk("s_oor_data", s_rs1Data, 32'd0);
    chk("s_oor_busy", {31'd0, s_rs1Busy}, 32'd0);
    chk("s_last_data", s_rs2Data, 32'h12345678);
    s_rs1Id = 5'd22;
    #1;
    chk("s_x22_busy", {31'd0, s_rs1Busy}, 32'd1);

    // reset mid-RUN with x3 busy, then again mid-CLEAR
    rs1Id = 5'd3; rs2Id = 5'd5;
    #1;
    chk("pre_rst_x3_busy", {31'd0, rs1Busy}, 32'd1);
    chk("pre_rst_x5_data", rs2Data, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    tick();
    chk("run_rst_ready", {31'd0, ready}, 32'd0);
    chk("run_rst_x5_gated", rs2Data, 32'd0);
    resetn = 1'b1;
    wrEn = 1'b1; rdId = 5'd4; rdData = 32'hBAD0BAD0;
    issue = 1'b1; issueRd = 5'd6;
    repeat (11) tick();
    chk("mid_clear_ready", {31'd0, ready}, 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    wait_ready(n1);
    idle();
    chk("restart_clear_cycles", n1, 32'd31);
    rs1Id = 5'd3; rs2Id = 5'd6;
    #1;
    chk("post_rst_x3_busy", {31'd0, rs1Busy}, 32'd0);
    chk("post_rst_x6_busy", {31'd0, rs2Busy}, 32'd0);
    rs1Id = 5'd4; rs2Id = 5'd5;
    #1;
    chk("post_rst_x4_data", rs1Data, 32'd0);
    chk("post_rst_x5_data", rs2Data, 32'd0);
    rs1Id = 5'd9; rs2Id = 5'd7;
    #1;
    chk("post_rst_x9_data", rs1Data, 32'd0);
    chk("post_rst_x7_data", rs2Data, 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
